// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/ack bus between fetch unit and memory
interface fetch_unit_if #(
  parameter int PC_WIDTH = 64
) ();
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic                imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem fetcher, fetch buffer, IR and immediate generator
module fetch_unit #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pc_write,
  input  logic                pc_write_cond,
  input  logic                branch_op,
  input  logic [1:0]          pc_src,
  input  logic                load_ir,
  input  logic [PC_WIDTH-1:0] alu_result,
  input  logic [PC_WIDTH-1:0] alu_out,
  input  logic                alu_zero,
  fetch_unit_if.master        imem,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         instruction,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [PC_WIDTH-1:0] imm,
  output logic                instr_valid,
  output logic                fetch_stall
);

  typedef enum logic [1:0] {START, FETCH, READY, IDLE} state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] fetch_addr;
  logic [31:0]         buffer;
  logic                discard;
  logic                take;
  logic                pc_we;

  function automatic logic [PC_WIDTH-1:0] immgen(input logic [31:0] w);
    logic [PC_WIDTH-1:0] r;
    r = '0;
    case (w[6:0])
      7'b0010011, 7'b0000011: r = {{(PC_WIDTH-12){w[31]}}, w[31:20]};
      7'b0100011:             r = {{(PC_WIDTH-12){w[31]}}, w[31:25], w[11:7]};
      7'b1100111:             r = {{(PC_WIDTH-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'b0110111:             r = {{(PC_WIDTH-32){w[31]}}, w[31:12], 12'b0};
      default:                r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    take  = pc_write_cond & (alu_zero ^ branch_op);
    pc_we = pc_write | take;
    case (pc_src)
      2'd0:    pc_next = alu_result;
      2'd1:    pc_next = alu_out;
      2'd2:    pc_next = {alu_out[PC_WIDTH-1:1], 1'b0};
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= START;
    else          state <= state_next;
  end

  // A returned word is only accepted when no PC write has overtaken the request.
  always_comb begin
    state_next = state;
    case (state)
      START: state_next = FETCH;
      FETCH: if (imem.imem_ack && !discard && !pc_we) state_next = READY;
      READY: begin
        if (pc_we)        state_next = FETCH;
        else if (load_ir) state_next = IDLE;
      end
      IDLE:  if (pc_we) state_next = FETCH;
      default: state_next = START;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   pc <= RESET_PC;
    else if (pc_we) pc <= pc_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr  <= RESET_PC;
      buffer      <= '0;
      instr_valid <= 1'b0;
      discard     <= 1'b0;
      instruction <= '0;
      imm         <= '0;
    end else begin
      case (state)
        START: begin
          fetch_addr <= pc;
          discard    <= pc_we;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            if (discard || pc_we) begin
              discard    <= 1'b0;
              fetch_addr <= pc_we ? pc_next : pc;
            end else begin
              buffer      <= imem.imem_rdata;
              instr_valid <= 1'b1;
            end
          end else if (pc_we) begin
            discard <= 1'b1;
          end
        end
        READY: begin
          if (load_ir) begin
            instruction <= buffer;
            imm         <= immgen(buffer);
          end
          if (load_ir || pc_we) instr_valid <= 1'b0;
          if (pc_we) fetch_addr <= pc_next;
        end
        IDLE: begin
          if (pc_we) fetch_addr <= pc_next;
        end
        default: ;
      endcase
    end
  end

  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = fetch_addr;
  assign rs1            = instruction[19:15];
  assign rs2            = instruction[24:20];
  assign rd             = instruction[11:7];
  assign fetch_stall    = load_ir & ~instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a behavioural fetch model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_write_cond = 1'b0;
  logic        branch_op = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic        load_ir = 1'b0;
  logic [63:0] alu_result = '0;
  logic [63:0] alu_out = '0;
  logic        alu_zero = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] imm;
  logic        instr_valid;
  logic        fetch_stall;

  int total = 0;
  int bad   = 0;

  // behavioural model: PC, outstanding request, staleness of that request, fetched word
  logic [63:0] m_pc, m_addr, m_imm;
  logic [31:0] m_ir, m_buf;
  logic        m_valid, m_req, m_stale, m_start;
  int          mwait = 1;
  bit          rand_lat = 0;

  fetch_unit_if #(.PC_WIDTH(64)) bus ();
  assign bus.imem_ack   = imem_ack;
  assign bus.imem_rdata = imem_rdata;

  fetch_unit #(.PC_WIDTH(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset_n(reset_n), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_op(branch_op), .pc_src(pc_src), .load_ir(load_ir), .alu_result(alu_result),
    .alu_out(alu_out), .alu_zero(alu_zero), .imem(bus), .pc(pc), .instruction(instruction),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .instr_valid(instr_valid), .fetch_stall(fetch_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    longint v;
    case (w[6:0])
      7'h13, 7'h03: v = longint'($signed(w[31:20]));
      7'h23:        v = longint'($signed({w[31:25], w[11:7]}));
      7'h67:        v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      7'h37:        v = longint'($signed({w[31:12], 12'h000}));
      default:      v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    logic [6:0]  opc;
    case (a)
      64'h0:  return 32'h00500093;
      64'h4:  return 32'h123450B7;
      64'h8:  return 32'hFE000EE7;
      64'h40: return 32'hFE112E23;
      default: begin
        h = (a[31:0] * 32'h9E3779B1) ^ a[63:32];
        case (h[2:0])
          3'd0: opc = 7'h13;
          3'd1: opc = 7'h03;
          3'd2: opc = 7'h23;
          3'd3: opc = 7'h67;
          3'd4: opc = 7'h37;
          default: opc = 7'h33;
        endcase
        return {h[31:7], opc};
      end
    endcase
  endfunction

  function automatic int next_lat();
    return rand_lat ? int'($urandom_range(0, 2)) : 1;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_addr = '0; m_imm = '0; m_ir = '0; m_buf = '0;
    m_valid = 0; m_req = 0; m_stale = 0; m_start = 1;
  endtask

  task automatic model_advance();
    logic [63:0] npc;
    logic        we;
    we = pc_write | (pc_write_cond & (alu_zero ^ branch_op));
    npc = (pc_src == 2'd0) ? alu_result :
          (pc_src == 2'd1) ? alu_out :
          (pc_src == 2'd2) ? (alu_out & ~64'd1) : m_pc;
    if (m_start) begin
      m_start = 0; m_req = 1; m_addr = m_pc; m_stale = we;
    end else if (m_req) begin
      if (imem_ack) begin
        if (m_stale || we) begin
          m_stale = 0;
          m_addr = we ? npc : m_pc;
        end else begin
          m_buf = imem_rdata; m_valid = 1; m_req = 0;
        end
      end else if (we) begin
        m_stale = 1;
      end
    end else if (m_valid) begin
      if (load_ir) begin
        m_ir = m_buf; m_imm = ref_imm(m_buf);
      end
      if (load_ir || we) m_valid = 0;
      if (we) begin m_req = 1; m_addr = npc; end
    end else if (we) begin
      m_req = 1; m_addr = npc;
    end
    if (we) m_pc = npc;
  endtask

  task automatic cyc(input logic rst, input logic pw, input logic pwc, input logic bop,
                     input logic [1:0] src, input logic ld, input logic [63:0] ar,
                     input logic [63:0] ao, input logic z);
    @(negedge clk);
    reset_n = rst; pc_write = pw; pc_write_cond = pwc; branch_op = bop;
    pc_src = src; load_ir = ld; alu_result = ar; alu_out = ao; alu_zero = z;
    if (!rst) begin
      model_reset();
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      mwait = next_lat();
    end else if (m_req) begin
      if (mwait == 0) begin
        imem_ack = 1'b1; imem_rdata = mem_word(m_addr); mwait = next_lat();
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom; mwait--;
      end
    end else begin
      imem_ack = 1'b0; imem_rdata = $urandom; mwait = next_lat();
    end
    #3;
    if (rst) model_advance();
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 2'd0, 0, 64'd0, 64'd0, 0);
  endtask

  task automatic wpc(input logic [63:0] a);
    cyc(1, 1, 0, 0, 2'd0, 0, a, 64'd0, 0);
  endtask

  task automatic ldir();
    cyc(1, 0, 0, 0, 2'd0, 1, 64'd0, 64'd0, 0);
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 20 && !m_valid; i++) idle();
    if (!m_valid) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    #2;
    chk("imem_req", 64'(bus.imem_req), 64'(m_req));
    chk("imem_addr", bus.imem_addr, m_addr);
    chk("pc", pc, m_pc);
    chk("instruction", 64'(instruction), 64'(m_ir));
    chk("imm", imm, m_imm);
    chk("instr_valid", 64'(instr_valid), 64'(m_valid));
    chk("rs1", 64'(rs1), 64'(m_ir[19:15]));
    chk("rs2", 64'(rs2), 64'(m_ir[24:20]));
    chk("rd", 64'(rd), 64'(m_ir[11:7]));
    chk("fetch_stall", 64'(fetch_stall), 64'(load_ir & ~m_valid));
  end

  initial begin
    model_reset();
    cyc(0, 0, 0, 0, 2'd0, 0, 64'd0, 64'd0, 0);
    chk("lit_reset_pc", pc, 64'd0);
    chk("lit_reset_req", 64'(bus.imem_req), 64'd0);
    chk("lit_reset_ir", 64'(instruction), 64'd0);
    chk("lit_reset_valid", 64'(instr_valid), 64'd0);
    idle();
    after_edge();
    chk("lit_first_req", 64'(bus.imem_req), 64'd1);
    chk("lit_first_addr", bus.imem_addr, 64'd0);
    wait_valid("first");
    after_edge();
    chk("lit_first_valid", 64'(instr_valid), 64'd1);
    ldir();
    after_edge();
    chk("lit_addi_ir", 64'(instruction), 64'h00500093);
    chk("lit_addi_rd", 64'(rd), 64'd1);
    chk("lit_addi_imm", imm, 64'd5);

    wpc(64'h8);
    wait_valid("sb");
    ldir();
    after_edge();
    chk("lit_sb_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1, 0, 1, 0, 2'd1, 0, 64'd0, 64'h10, 1);
    after_edge();
    chk("lit_beq_taken", pc, 64'h10);
    cyc(1, 0, 1, 0, 2'd1, 0, 64'd0, 64'h20, 0);
    after_edge();
    chk("lit_beq_not_taken", pc, 64'h10);
    wait_valid("beq");
    cyc(1, 0, 1, 1, 2'd1, 0, 64'd0, 64'h40, 0);
    after_edge();
    chk("lit_bne_pc", pc, 64'h40);
    chk("lit_bne_req", 64'(bus.imem_req), 64'd1);
    chk("lit_bne_addr", bus.imem_addr, 64'h40);
    wait_valid("bne");
    ldir();
    after_edge();
    chk("lit_s_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);

    wpc(64'h4);
    wpc(64'h8);
    idle();
    after_edge();
    chk("lit_drop_valid", 64'(instr_valid), 64'd0);
    chk("lit_drop_req", 64'(bus.imem_req), 64'd1);
    chk("lit_drop_addr", bus.imem_addr, 64'h8);
    ldir();
    chk("lit_stall", 64'(fetch_stall), 64'd1);
    after_edge();
    chk("lit_stall_ir_kept", 64'(instruction), 64'hFE112E23);
    wait_valid("refetch");
    ldir();
    after_edge();
    chk("lit_refetch_ir", 64'(instruction), 64'hFE000EE7);
    wpc(64'h4);
    wait_valid("u");
    ldir();
    after_edge();
    chk("lit_u_imm", imm, 64'h0000_0000_1234_5000);

    wpc(64'h40);
    idle();
    cyc(0, 0, 0, 0, 2'd0, 0, 64'd0, 64'd0, 0);
    chk("lit_rst_req_drop", 64'(bus.imem_req), 64'd0);
    chk("lit_rst_pc", pc, 64'd0);
    cyc(0, 0, 0, 0, 2'd0, 0, 64'd0, 64'd0, 0);
    idle();
    after_edge();
    chk("lit_rst_refetch_req", 64'(bus.imem_req), 64'd1);
    chk("lit_rst_refetch_addr", bus.imem_addr, 64'd0);

    rand_lat = 1;
    for (int n = 0; n < 4000; n++) begin
      cyc(logic'($urandom_range(0, 249) != 0),
          logic'($urandom_range(0, 7) == 0),
          logic'($urandom_range(0, 5) == 0),
          1'($urandom), 2'($urandom), logic'($urandom_range(0, 2) == 0),
          {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    end
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle control unit.
- Owns the 64-bit PC and drives an instruction memory through a req/ack handshake.
- Buffers the fetched word and loads it into the instruction register (IR) on the control unit's LoadIR.
- Produces the instruction word, register fields and sign-extended immediate. Applies PCWrite/PCWriteCond/BranchOp/PCSrc from the control unit.

Parameters:
- PC_WIDTH, 64, width of PC and address/ALU buses
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- pc_write  in  1  unconditional PC write (control unit PCWrite)
- pc_write_cond  in  1  conditional PC write (PCWriteCond)
- branch_op  in  1  0=BEQ (take if zero), 1=BNE (take if not zero)
- pc_src  in  2  next-PC select
- load_ir  in  1  copy fetch buffer into IR (LoadIR)
- alu_result  in  PC_WIDTH  combinational ALU output
- alu_out  in  PC_WIDTH  ALUOut register value
- alu_zero  in  1  ALU zero flag
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address
- imem_rdata  in  32  fetched word, valid when imem_ack=1
- imem_ack  in  1  one-cycle completion pulse
- pc  out  PC_WIDTH  current PC
- instruction  out  32  IR contents
- rs1, rs2, rd  out  5 each  IR[19:15], IR[24:20], IR[11:7]
- imm  out  PC_WIDTH  sign-extended immediate, registered with IR
- instr_valid  out  1  fetch buffer holds an unconsumed word
- fetch_stall  out  1  load_ir & ~instr_valid (combinational)

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, instruction=0, imm=0, buffer=0, instr_valid=0, discard=0.
  - fetch_addr=RESET_PC, state=START, imem_req=0.
- PC update:
  - take = pc_write_cond & (alu_zero ^ branch_op); pc_we = pc_write | take.
  - Next PC by pc_src: 0 → alu_result; 1 → alu_out; 2 → {alu_out[PC_WIDTH-1:1],1'b0}; 3 → hold.
  - pc registered on the edge where pc_we=1. No alignment check. Arithmetic wraps naturally.
- FSM states: START, FETCH, READY, IDLE.
  - imem_req = (state==FETCH); imem_addr = fetch_addr.
  - START: next FETCH; fetch_addr<=pc. First request is in the cycle after reset release.
  - FETCH: imem_req held high until imem_ack; fetch_addr stable for the whole request.
    - On ack with discard=0: buffer<=imem_rdata, instr_valid<=1 → READY.
    - On ack with discard=1: data dropped, discard<=0, fetch_addr<=pc (new value) → stay FETCH.
    - pc_we in FETCH without ack: discard<=1.
    - pc_we and ack in the same cycle: data dropped; refetch from the next-PC value.
  - READY: wait for load_ir.
    - load_ir: instruction<=buffer, imm<=immgen(buffer), instr_valid<=0 → IDLE.
    - pc_we without load_ir: buffer stale, instr_valid<=0, fetch_addr<=next PC → FETCH.
    - load_ir and pc_we together: IR loads buffer, fetch_addr<=next PC → FETCH.
  - IDLE: on pc_we, fetch_addr<=next PC → FETCH. Otherwise hold.
    - load_ir in IDLE: IR unchanged; fetch_stall=1.
- Total fetch latency: request cycle to instr_valid = memory latency + 1 edge.
- Immediate generation (sign bit IR[31]), by opcode IR[6:0]:
  - 0010011, 0000011 (I): IR[31:20].
  - 0100011 (S): {IR[31:25],IR[11:7]}.
  - 1100111 (SB): {IR[31],IR[7],IR[30:25],IR[11:8],1'b0}.
  - 0110111 (U): {IR[31:12],12'b0}.
  - Others: 0.
- rs1/rs2/rd are combinational slices of IR.
- Reset mid-request: imem_req drops immediately, FSM returns to START. An ack arriving during reset is ignored.

Test Plan:
- Reset, release, 2-cycle memory returning 32'h00500093 at addr 0 → imem_req high from cycle 1 with addr 0. instr_valid=1 after ack. load_ir → instruction=32'h00500093, rd=1, imm=5.
- IR=SB word 32'hFE000EE7 (BEQ, imm −4), pc_write_cond=1, branch_op=0, alu_zero=1, pc_src=1, alu_out=64'h10 → pc=64'h10. Repeat with alu_zero=0 → pc unchanged.
- BNE: branch_op=1, alu_zero=0, pc_src=1, alu_out=64'h40 → pc=64'h40. Refetch issued at addr 64'h40.
- pc_write=1 (pc_src=0, alu_result=64'h8) during an outstanding fetch of addr 4 → ack data dropped, second request at addr 8, instr_valid only after the second ack.
- load_ir with instr_valid=0 → fetch_stall=1, instruction unchanged. U-type 32'h123450B7 loaded → imm=64'h0000000012345000. S-type with IR[31]=1 → imm upper bits all 1.
- reset_n pulsed low mid-FETCH → imem_req=0 same cycle, pc=RESET_PC. Fresh request at RESET_PC one cycle after release.
